// File: rtl/hack_spi_sram_pkg.sv
// hack_spi_sram_pkg: SRAM opcodes, frame size and controller states shared by
// the SPI SRAM arbiter and its shifter.
package hack_spi_sram_pkg;
    localparam logic [7:0] SRAM_OP_READ  = 8'h03;
    localparam logic [7:0] SRAM_OP_WRITE = 8'h02;
    localparam int FRAME_BITS   = 48;
    localparam int SHIFT_CYCLES = 2 * FRAME_BITS;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_DESEL
    } sram_state_t;
endpackage

// File: rtl/hack_spi_sram_shifter.sv
// hack_spi_sram_shifter: serialises one 48-bit frame MSB first at clock/2 on
// sck/mosi and collects the trailing 16 miso samples as the read word.
module hack_spi_sram_shifter
    import hack_spi_sram_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic [FRAME_BITS-1:0] frame_i,
    input  logic                  en_i,
    input  logic                  miso_i,
    output logic                  sck_o,
    output logic                  mosi_o,
    output logic                  done_o,
    output logic [15:0]           rx_o
);
    logic [FRAME_BITS-1:0] tx_q, tx_d;
    logic [15:0]           rx_q, rx_d;
    logic [6:0]            cnt_q, cnt_d;
    logic                  high;

    // odd counts are the sck-high phase; its closing edge samples miso and advances the frame
    assign high = en_i & cnt_q[0];

    always_comb begin
        cnt_d = load_i ? 7'd0 : en_i ? cnt_q + 7'd1 : cnt_q;
        tx_d  = load_i ? frame_i : high ? {tx_q[FRAME_BITS-2:0], 1'b0} : tx_q;
        rx_d  = high ? {rx_q[14:0], miso_i} : rx_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            tx_q  <= '0;
            rx_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            tx_q  <= tx_d;
            rx_q  <= rx_d;
        end
    end

    assign sck_o  = high;
    assign mosi_o = en_i & tx_q[FRAME_BITS-1];
    assign done_o = en_i & (cnt_q == 7'(SHIFT_CYCLES - 1));
    assign rx_o   = rx_q;
endmodule

// File: rtl/hack_spi_sram_arbiter.sv
// hack_spi_sram_arbiter: shares one 23LC1024 SPI SRAM between two Hack word ports.
// HACK_SPI_ARB_RR_EN selects round-robin arbitration; otherwise port 0 has fixed priority.
module hack_spi_sram_arbiter
    import hack_spi_sram_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int DESEL_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [15:0]       wdata0,
    input  logic [15:0]       wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [15:0]       rdata,
    output logic              busy,
    output logic              sram_cs_n,
    output logic              sram_sck,
    output logic              sram_mosi,
    input  logic              sram_miso,
    output logic              sram_hold_n
);
    localparam int DW = $clog2(DESEL_CYCLES + 1);

    sram_state_t           state_q, state_d;
    logic                  gnt_q, we_q, sel, grant, ack_first, we_s, done;
    logic [DW-1:0]         dcnt_q, dcnt_d;
    logic [15:0]           rdata_q, rdata_d, rx, wdata_s;
    logic [ADDR_W-1:0]     addr_s;
    logic [23:0]           baddr;
    logic [FRAME_BITS-1:0] frame;

    assign grant = (state_q == ST_IDLE) & (req0 | req1);

`ifdef HACK_SPI_ARB_RR_EN
    logic ptr_q;
    // ptr_q names the port preferred on a tie: always the one not granted last
    assign sel = (req0 & req1) ? ptr_q : req1;
    always_ff @(posedge clock) begin
        if (reset)
            ptr_q <= 1'b0;
        else if (grant)
            ptr_q <= ~sel;
    end
`else
    assign sel = ~req0;
`endif

    assign we_s    = sel ? we1 : we0;
    assign addr_s  = sel ? addr1 : addr0;
    assign wdata_s = sel ? wdata1 : wdata0;
    assign baddr   = {{(23-ADDR_W){1'b0}}, addr_s, 1'b0};
    assign frame   = {we_s ? SRAM_OP_WRITE : SRAM_OP_READ, baddr, we_s ? wdata_s : 16'h0};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            gnt_q   <= 1'b0;
            we_q    <= 1'b0;
            dcnt_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            rdata_q <= rdata_d;
            if (grant) begin
                gnt_q <= sel;
                we_q  <= we_s;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = grant ? ST_SETUP : ST_IDLE;
            ST_SETUP: state_d = ST_SHIFT;
            ST_SHIFT: state_d = done ? ST_HOLD : ST_SHIFT;
            ST_HOLD:  state_d = ST_DESEL;
            ST_DESEL: state_d = (dcnt_q == DW'(DESEL_CYCLES - 1)) ? ST_IDLE : ST_DESEL;
            default:  state_d = ST_IDLE;
        endcase
        dcnt_d  = (state_q == ST_DESEL) ? dcnt_q + DW'(1) : '0;
        rdata_d = (state_q == ST_HOLD && !we_q) ? rx : rdata_q;
    end

    always_comb begin
        ack_first = (state_q == ST_DESEL) && (dcnt_q == '0);
        ack0      = ack_first & ~gnt_q;
        ack1      = ack_first & gnt_q;
        busy      = state_q != ST_IDLE;
        sram_cs_n = (state_q == ST_IDLE) || (state_q == ST_DESEL);
    end

    assign rdata       = rdata_q;
    assign sram_hold_n = 1'b1;

    hack_spi_sram_shifter u_shifter (
        .clk_i   (clock),
        .rst_i   (reset),
        .load_i  (grant),
        .frame_i (frame),
        .en_i    (state_q == ST_SHIFT),
        .miso_i  (sram_miso),
        .sck_o   (sram_sck),
        .mosi_o  (sram_mosi),
        .done_o  (done),
        .rx_o    (rx)
    );
endmodule

// File: tb/tb_hack_spi_sram_arbiter.sv
// tb_hack_spi_sram_arbiter: randomized word traffic against a byte-level 23LC1024
// model on the pins and a word-level expected memory.
module tb_hack_spi_sram_arbiter;
    localparam int DESEL   = 2;
    localparam int ACK_LAT = 99;
    localparam int PERIOD  = 99 + DESEL;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [15:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        ack0, ack1, busy, sram_cs_n, sram_sck, sram_mosi, sram_hold_n;
    logic        sram_miso = 1'b0;
    logic [15:0] rdata;

    int tests = 0;
    int fails = 0;

    bit [15:0] exp_mem [0:65535];
    logic [15:0] last_rd = '0;

    hack_spi_sram_arbiter #(.ADDR_W(16), .DESEL_CYCLES(DESEL)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
        .sram_cs_n(sram_cs_n), .sram_sck(sram_sck), .sram_mosi(sram_mosi),
        .sram_miso(sram_miso), .sram_hold_n(sram_hold_n)
    );

    always #5 clock = ~clock;

    // SPI SRAM pin model: mosi captured at each observed sck rise, read data driven for the high phase
    bit [7:0]    sram [0:131071];
    logic [47:0] sl_bits = '0;
    logic [47:0] last_frame = '0;
    logic [7:0]  sl_op = '0;
    logic [16:0] sl_addr = '0;
    logic        sl_sck_prev = 1'b0;
    logic        sl_active = 1'b0;
    int          sl_n = 0;
    int          last_rises = 0;

    always @(negedge clock) begin
        if (sram_cs_n) begin
            if (sl_active && sl_n == 48 && sl_bits[47:40] == 8'h02) begin
                sram[sl_bits[32:16]]         = sl_bits[15:8];
                sram[sl_bits[32:16] + 17'd1] = sl_bits[7:0];
            end
            if (sl_active) begin
                last_frame = sl_bits;
                last_rises = sl_n;
            end
            sl_active = 1'b0;
            sl_n      = 0;
            sl_bits   = '0;
            sram_miso = 1'b0;
        end else begin
            sl_active = 1'b1;
            if (sram_sck && !sl_sck_prev) begin
                sl_bits = {sl_bits[46:0], sram_mosi};
                if (sl_n == 31) begin
                    sl_op   = sl_bits[31:24];
                    sl_addr = sl_bits[16:0];
                end
                if (sl_n >= 32 && sl_n < 48 && sl_op == 8'h03) begin
                    automatic int       j  = sl_n - 32;
                    automatic bit [7:0] bt = sram[sl_addr + 17'(j / 8)];
                    sram_miso = bt[7 - (j % 8)];
                end
                sl_n++;
            end
        end
        sl_sck_prev = sram_sck;
    end

    function automatic logic [47:0] exp_frame(input bit w, input logic [15:0] a, input logic [15:0] d);
        return {w ? 8'h02 : 8'h03, 7'b0, a, 1'b0, w ? d : 16'h0};
    endfunction

    // Drives one transaction from IDLE at a negedge and reports what was observed.
    task automatic run_xfer(input int p, input bit w, input logic [15:0] a, input logic [15:0] d,
                            output int lat, output logic [15:0] rd, output bit other,
                            output bit wide, output logic [2:0] st1);
        lat = -1; rd = 'x; other = 1'b0; st1 = 'x;
        if (p == 0) begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; end
        else        begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; end
        for (int i = 1; i <= 400; i++) begin
            @(negedge clock);
            if (i == 1) st1 = {sram_cs_n, busy, sram_sck};
            if ((p == 0) ? ack1 : ack0) other = 1'b1;
            if ((p == 0) ? ack0 : ack1) begin
                lat = i;
                rd  = rdata;
                break;
            end
        end
        req0 = 0; req1 = 0;
        @(negedge clock);
        wide = (p == 0) ? ack0 : ack1;
        for (int i = 0; i < 20 && busy; i++) @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        tests++;
        if ({sram_cs_n, sram_sck, sram_mosi, ack0, ack1, busy, sram_hold_n} !== 7'b1000001) begin
            fails++;
            $display("FAIL reset_pins got %b want 1000001", {sram_cs_n, sram_sck, sram_mosi, ack0, ack1, busy, sram_hold_n});
        end
        tests++;
        if (rdata !== 16'h0) begin fails++; $display("FAIL reset_rdata got %h want 0000", rdata); end
        reset = 1'b0;
        last_rd = '0;
        @(negedge clock);
    endtask

    task automatic test_write_read();
        int lat; logic [15:0] rd; bit oth, wide; logic [2:0] st1;
        run_xfer(0, 1, 16'h0005, 16'hBEEF, lat, rd, oth, wide, st1);
        exp_mem[16'h0005] = 16'hBEEF;
        tests++;
        if (lat !== ACK_LAT) begin fails++; $display("FAIL wr_ack_latency got %0d want %0d", lat, ACK_LAT); end
        tests++;
        if (st1 !== 3'b010) begin fails++; $display("FAIL wr_grant_cycle cs_n/busy/sck got %b want 010", st1); end
        tests++;
        if (last_frame !== 48'h02_00000A_BEEF) begin fails++; $display("FAIL wr_frame got %h want 0200000abeef", last_frame); end
        tests++;
        if (last_rises !== 48) begin fails++; $display("FAIL wr_sck_rises got %0d want 48", last_rises); end
        tests++;
        if ({sram[10], sram[11]} !== 16'hBEEF) begin fails++; $display("FAIL wr_sram_bytes got %h want beef", {sram[10], sram[11]}); end
        tests++;
        if (rd !== last_rd) begin fails++; $display("FAIL wr_rdata_held got %h want %h", rd, last_rd); end
        tests++;
        if (oth || wide) begin fails++; $display("FAIL wr_ack_shape other=%b wide=%b want 0 0", oth, wide); end
        run_xfer(1, 0, 16'h0005, 16'h0000, lat, rd, oth, wide, st1);
        tests++;
        if (lat !== ACK_LAT) begin fails++; $display("FAIL rd_ack_latency got %0d want %0d", lat, ACK_LAT); end
        tests++;
        if (rd !== 16'hBEEF) begin fails++; $display("FAIL rd_data got %h want beef", rd); end
        tests++;
        if (last_frame !== 48'h03_00000A_0000) begin fails++; $display("FAIL rd_frame got %h want 0300000a0000", last_frame); end
        tests++;
        if (oth || wide) begin fails++; $display("FAIL rd_ack_shape ack0_seen=%b wide=%b want 0 0", oth, wide); end
        last_rd = 16'hBEEF;
    endtask

    task automatic test_random();
        logic [15:0] pool [6];
        pool[0] = 16'h0000; pool[1] = 16'hFFFF; pool[2] = 16'h0005;
        pool[3] = 16'h7FFF; pool[4] = 16'h8001; pool[5] = 16'h00A5;
        for (int n = 0; n < 24; n++) begin
            int lat; logic [15:0] rd, exp_rd; bit oth, wide; logic [2:0] st1;
            int          p = int'($urandom_range(0, 1));
            bit          w = 1'($urandom_range(0, 1));
            logic [15:0] a = pool[$urandom_range(0, 5)];
            logic [15:0] d = 16'($urandom);
            exp_rd = w ? last_rd : exp_mem[a];
            run_xfer(p, w, a, d, lat, rd, oth, wide, st1);
            if (w) exp_mem[a] = d;
            else   last_rd = exp_mem[a];
            tests++;
            if (lat !== ACK_LAT || oth || wide) begin
                fails++;
                $display("FAIL rand%0d_ack port%0d lat=%0d other=%b wide=%b want %0d 0 0", n, p, lat, oth, wide, ACK_LAT);
            end
            tests++;
            if (last_frame !== exp_frame(w, a, d)) begin
                fails++;
                $display("FAIL rand%0d_frame got %h want %h", n, last_frame, exp_frame(w, a, d));
            end
            tests++;
            if (rd !== exp_rd) begin fails++; $display("FAIL rand%0d_rdata we=%b addr=%h got %h want %h", n, w, a, rd, exp_rd); end
        end
    endtask

    task automatic test_both_pending();
        int seq [4]; int t [4]; int n = 0;
        int lat; logic [15:0] rd; bit oth, wide; logic [2:0] st1;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        last_rd = '0;
        req0 = 1; we0 = 1; addr0 = 16'h0300; wdata0 = 16'h1357;
        req1 = 1; we1 = 1; addr1 = 16'h1234; wdata1 = 16'h2468;
        for (int i = 1; i <= 700 && n < 4; i++) begin
            @(negedge clock);
            if (ack0 && n < 4) begin seq[n] = 0; t[n] = i; n++; end
            if (ack1 && n < 4) begin seq[n] = 1; t[n] = i; n++; end
        end
        req0 = 0; req1 = 0;
        for (int i = 0; i < 20 && busy; i++) @(negedge clock);
        exp_mem[16'h0300] = 16'h1357;
`ifdef HACK_SPI_ARB_RR_EN
        exp_mem[16'h1234] = 16'h2468;
`endif
        tests++;
        if (n !== 4) begin fails++; $display("FAIL both_ack_count got %0d want 4", n); end
        for (int k = 0; k < n; k++) begin
`ifdef HACK_SPI_ARB_RR_EN
            automatic int want_p = k % 2;
`else
            automatic int want_p = 0;
`endif
            automatic int want_t = ACK_LAT + k * PERIOD;
            tests++;
            if (seq[k] !== want_p || t[k] !== want_t) begin
                fails++;
                $display("FAIL both_ack%0d got port%0d@%0d want port%0d@%0d", k, seq[k], t[k], want_p, want_t);
            end
        end
        run_xfer(1, 0, 16'h1234, 16'h0000, lat, rd, oth, wide, st1);
        tests++;
        if (rd !== exp_mem[16'h1234]) begin fails++; $display("FAIL both_port1_word got %h want %h", rd, exp_mem[16'h1234]); end
        last_rd = rd;
    endtask

    task automatic test_mid_request();
        int t0 = -1, t1 = -1, n0 = 0, n1 = 0; logic [15:0] rd = 'x;
        req0 = 1; we0 = 1; addr0 = 16'h4242; wdata0 = 16'hC0DE;
        for (int i = 1; i <= 500; i++) begin
            @(negedge clock);
            if (i == 40) begin req1 = 1; we1 = 0; addr1 = 16'h4242; end
            if (ack0) begin n0++; t0 = i; req0 = 0; end
            if (ack1) begin n1++; t1 = i; rd = rdata; req1 = 0; break; end
        end
        req0 = 0; req1 = 0;
        for (int i = 0; i < 20 && busy; i++) @(negedge clock);
        exp_mem[16'h4242] = 16'hC0DE;
        tests++;
        if (n0 !== 1 || t0 !== ACK_LAT) begin fails++; $display("FAIL mid_ack0 count=%0d at=%0d want 1 at %0d", n0, t0, ACK_LAT); end
        tests++;
        if (n1 !== 1 || t1 !== ACK_LAT + PERIOD) begin fails++; $display("FAIL mid_ack1 count=%0d at=%0d want 1 at %0d", n1, t1, ACK_LAT + PERIOD); end
        tests++;
        if (rd !== 16'hC0DE) begin fails++; $display("FAIL mid_rdata got %h want c0de", rd); end
        last_rd = 16'hC0DE;
    endtask

    task automatic test_reset_abort();
        int acks = 0; int lat; logic [15:0] rd; bit oth, wide; logic [2:0] st1;
        req0 = 1; we0 = 0; addr0 = 16'h0300;
        repeat (40) @(negedge clock);
        reset = 1'b1;
        req0 = 0;
        @(negedge clock);
        tests++;
        if ({sram_cs_n, sram_sck, sram_mosi, busy, ack0, ack1} !== 6'b100000) begin
            fails++;
            $display("FAIL abort_pins got %b want 100000", {sram_cs_n, sram_sck, sram_mosi, busy, ack0, ack1});
        end
        tests++;
        if (rdata !== 16'h0) begin fails++; $display("FAIL abort_rdata got %h want 0000", rdata); end
        reset = 1'b0;
        last_rd = '0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clock);
            if (ack0 || ack1) acks++;
        end
        tests++;
        if (acks !== 0) begin fails++; $display("FAIL abort_no_ack got %0d acks want 0", acks); end
        run_xfer(0, 0, 16'h0300, 16'h0000, lat, rd, oth, wide, st1);
        tests++;
        if (lat !== ACK_LAT || rd !== exp_mem[16'h0300]) begin
            fails++;
            $display("FAIL abort_reissue lat=%0d data=%h want %0d %h", lat, rd, ACK_LAT, exp_mem[16'h0300]);
        end
        last_rd = rd;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_random();
        test_both_pending();
        test_mid_request();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hack_spi_sram_arbiter.md
# hack_spi_sram_arbiter

Controller that shares one 23LC1024 SPI SRAM (single-bit SPI, mode 0) between two 16-bit Hack word requesters: port 0 (CPU data) and port 1 (display/VRAM fetch). It arbitrates pending requests, serializes one READ or WRITE word transaction at a time onto the SRAM pins routed through `mprj_io`, and returns read data with a one-cycle acknowledge. One instance sits in front of each external SRAM (ram, rom, vram) inside the user project wrapper.

## Interface
Parameters:
- `ADDR_W`, 16, word address width; byte address sent is `{(23-ADDR_W)'b0, addr, 1'b0}`.
- `DESEL_CYCLES`, 2, cycles CS_N held high between transactions (≥1).

Ports:
- `clock`  in  1  system clock. One clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `req0`, `req1`  in  1  request, held high until matching ack.
- `we0`, `we1`  in  1  1 = write, 0 = read; stable while req high.
- `addr0`, `addr1`  in  ADDR_W  word address; stable while req high.
- `wdata0`, `wdata1`  in  16  write data; stable while req high.
- `ack0`, `ack1`  out  1  one-cycle completion pulse.
- `rdata`  out  16  read data, valid in the ack cycle, held until next ack.
- `busy`  out  1  high from grant until return to IDLE.
- `sram_cs_n`  out  1  chip select (SRAM CS_N).
- `sram_sck`  out  1  serial clock, idle low.
- `sram_mosi`  out  1  to SIO0/SI.
- `sram_miso`  in  1  from SIO1/SO.
- `sram_hold_n`  out  1  constant 1 (HOLD_N_SIO3 inactive).

## Operation
- States: IDLE → SETUP (1 cycle) → SHIFT (96 cycles) → HOLD (1) → DESEL (DESEL_CYCLES) → IDLE.
- IDLE: if any req, grant per arbitration, latch we/addr/wdata of winner, load 48-bit frame {opcode[7:0], byte_addr[23:0], data[15:0]}; opcode 0x03 read, 0x02 write; data field 0 for reads.
- SHIFT: 48 bits MSB first, 2 cycles each: low phase (sck=0, mosi=frame bit), high phase (sck=1); miso sampled on the edge ending each high phase; last 16 samples form rdata (first sampled = bit 15).
- SETUP, HOLD: cs_n=0, sck=0, mosi=0. DESEL: cs_n=1; ack of granted port high in first DESEL cycle only; rdata updated same cycle (reads only; writes leave rdata unchanged).
- Non-granted request stays pending; it is never dropped.
- Requests arriving in any non-IDLE state wait; no queueing beyond the held req lines.
- Reset (any state, incl. mid-SHIFT): cs_n=1, sck=0, mosi=0, ack0=ack1=0, rdata=0, busy=0, state IDLE, arbitration pointer prefers port 0. An aborted transaction produces no ack; requester must re-present.

## Timing
- Grant edge k (IDLE samples req): cs_n falls after edge k; SHIFT occupies cycles after edges k+1…k+96; HOLD after k+97; cs_n rises and ack pulses after k+98; IDLE reached after k+98+DESEL_CYCLES.
- Request-to-ack: 98 cycles from grant edge; back-to-back throughput one word per 99+DESEL_CYCLES cycles (101 default).
- SCK = clock/2 during SHIFT; 48 rising SCK edges per transaction exactly.
- Requester drops or changes req the cycle after ack; IDLE samples it at the end of its first cycle, so a held-high req after ack starts a new transaction.

## Configuration
- `HACK_SPI_ARB_RR_EN` defined: round-robin; when both req in IDLE, grant port not granted last; pointer toggles to the other port on every grant.
- Undefined: fixed priority, port 0 always wins ties; port 1 served only when req0 low in IDLE.

## Structure
- Package `hack_spi_sram_pkg`: opcodes `SRAM_OP_READ`=0x03, `SRAM_OP_WRITE`=0x02, `FRAME_BITS`=48, state enum `sram_state_t`.
- Sub-module `hack_spi_sram_shifter`: 48-bit shift register, bit/phase counter, sck/mosi generation, miso capture; arbiter/FSM in top.

## Test plan
- Port 0 write 0xBEEF to addr 0x0005 → frame 0x02,0x00000A,0xBEEF on mosi, 48 sck rises, ack0 after 98 cycles; model holds bytes 0x0A=0xBE, 0x0B=0xEF.
- Port 1 read addr 0x0005 after above → opcode 0x03, rdata=0xBEEF with ack1, ack0 stays 0.
- req0 and req1 both high continuously → with RR_EN acks alternate 0,1,0,1 at 101-cycle spacing; without, only ack0 while req0 held.
- req1 raised mid-transaction of port 0 → port 1 granted in the IDLE cycle after DESEL, no lost or duplicated ack.
- Reset asserted at cycle k+40 of a read → next cycle cs_n=1, sck=0, busy=0, no ack; re-issued read returns correct data.
- DESEL_CYCLES=1 build → cs_n high exactly 1 cycle between back-to-back transactions, period 100 cycles.
